rr_arbiter_burst: RTL and testbench

- Parametrised round-robin arbiter for N requesters with a registered one-hot grant, encoded grant index and grant-valid flag.
- The current owner keeps the grant for up to BURST_LEN consecutive cycles while it keeps requesting, then priority rotates.
- The rotation pointer is retained across idle periods, so fairness holds across gaps in traffic.
- Sits in front of shared resources (bus, memory port) and replaces fixed 4-way state-machine arbiters.

---
 rtl/rr_arbiter_burst.sv | 96 +++++++++
 tb/tb_rr_arbiter_burst.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_burst.sv
// Round-robin arbiter with burst hold.
// The current owner may keep the grant for up to BURST_LEN consecutive cycles
// while it keeps requesting; after that, priority rotates to the next requester.
// The rotation pointer survives idle periods, so fairness carries across gaps.
module rr_arbiter_burst #(
   parameter int N         = 4,
   parameter int BURST_LEN = 1,
   parameter int IDW       = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_id,
   output logic           grant_valid,
   output logic           burst_last
);

   // Burst counter width: enough to hold BURST_LEN-1, never narrower than one bit.
   localparam int CW = ($clog2(BURST_LEN + 1) < 1) ? 1 : $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

   logic [N-1:0]   r_grant;
   logic [IDW-1:0] r_grantId;
   logic           r_grantValid;
   logic [IDW-1:0] r_last;
   logic [CW-1:0]  r_burstCnt;

   logic           w_atLast;
   logic           w_hold;
   logic           w_found;
   logic [IDW-1:0] w_winner;
   logic [N-1:0]   w_onehot;

   // The counter never exceeds LAST_CNT, so "not at last" is the same as "below last".
   assign w_atLast = (r_burstCnt == LAST_CNT);
   assign w_hold   = r_grantValid && req[r_grantId] && !w_atLast;

   // Rotating priority search: start just after the last owner, wrap at N,
   // and end on the last owner itself so it has the lowest priority.
   always_comb begin
      int idx;
      logic [IDW-1:0] cand;
      w_found  = 1'b0;
      w_winner = '0;
      idx      = 0;
      cand     = '0;
      for (int k = 1; k <= N; k++) begin
         idx = int'(r_last) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         cand = IDW'(idx);
         if (!w_found && req[cand]) begin
            w_found  = 1'b1;
            w_winner = cand;
         end
      end
   end

   // One-hot form of the search winner.
   always_comb begin
      w_onehot           = '0;
      w_onehot[w_winner] = 1'b1;
   end

   // Grant state: hold the owner mid-burst, otherwise take the search result,
   // or go idle while keeping the pointer and the last reported index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant      <= '0;
         r_grantId    <= '0;
         r_grantValid <= 1'b0;
         r_last       <= IDW'(N - 1);
         r_burstCnt   <= '0;
      end else if (w_hold) begin
         r_burstCnt   <= r_burstCnt + CW'(1);
      end else if (w_found) begin
         r_grant      <= w_onehot;
         r_grantId    <= w_winner;
         r_grantValid <= 1'b1;
         r_last       <= w_winner;
         r_burstCnt   <= '0;
      end else begin
         r_grant      <= '0;
         r_grantValid <= 1'b0;
         r_burstCnt   <= '0;
      end
   end

   assign grant       = r_grant;
   assign grant_id    = r_grantId;
   assign grant_valid = r_grantValid;
   assign burst_last  = r_grantValid && w_atLast;

endmodule

// File: tb/tb_rr_arbiter_burst.sv
// Testbench for rr_arbiter_burst: three configurations driven side by side
// (N=4/BURST_LEN=1, N=4/BURST_LEN=3, N=5/BURST_LEN=1), with a queue-based
// scoreboard fed by a behavioural model of owners, burst lengths and rotation.
module tb_rr_arbiter_burst;

   logic       clk;
   logic       rst;
   logic [3:0] reqA, reqB;
   logic [4:0] reqC;
   logic [3:0] grantA, grantB;
   logic [4:0] grantC;
   logic [1:0] idA, idB;
   logic [2:0] idC;
   logic       validA, validB, validC;
   logic       lastA, lastB, lastC;

   rr_arbiter_burst #(.N(4), .BURST_LEN(1)) uA (
      .clk(clk), .rst(rst), .req(reqA), .grant(grantA),
      .grant_id(idA), .grant_valid(validA), .burst_last(lastA)
   );

   rr_arbiter_burst #(.N(4), .BURST_LEN(3)) uB (
      .clk(clk), .rst(rst), .req(reqB), .grant(grantB),
      .grant_id(idB), .grant_valid(validB), .burst_last(lastB)
   );

   rr_arbiter_burst #(.N(5), .BURST_LEN(1)) uC (
      .clk(clk), .rst(rst), .req(reqC), .grant(grantC),
      .grant_id(idC), .grant_valid(validC), .burst_last(lastC)
   );

   typedef struct {
      int inst;
      int grantV;
      int id;
      int valid;
      int last;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   checks = 0;
   int   errors = 0;

   // Reference model state, per instance: who owns the grant, how many cycles
   // it has held it in the current burst, and who owned it most recently.
   int mN[3]  = '{4, 4, 5};
   int mBL[3] = '{1, 3, 1};
   int mLast[3];
   int mId[3];
   int mHeld[3];
   int mValid[3];

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < 3; i++) begin
         mLast[i]  = mN[i] - 1;
         mId[i]    = 0;
         mHeld[i]  = 0;
         mValid[i] = 0;
      end
   endtask

   // One cycle of arbitration as described in words: keep a requesting owner
   // until it has had BURST_LEN cycles, otherwise pick the first requester
   // found walking forward from the previous owner.
   function automatic exp_t modelStep(input int inst, input int r);
      exp_t e;
      int   n;
      n = mN[inst];
      if (mValid[inst] != 0 && ((r >> mId[inst]) & 1) == 1 && mHeld[inst] < mBL[inst]) begin
         mHeld[inst]++;
      end else if (r == 0) begin
         mValid[inst] = 0;
         mHeld[inst]  = 0;
      end else begin
         for (int k = 1; k <= n; k++) begin
            int c;
            c = (mLast[inst] + k) % n;
            if (((r >> c) & 1) == 1) begin
               mId[inst]    = c;
               mLast[inst]  = c;
               mHeld[inst]  = 1;
               mValid[inst] = 1;
               break;
            end
         end
      end
      e.inst   = inst;
      e.grantV = (mValid[inst] != 0) ? (1 << mId[inst]) : 0;
      e.id     = mId[inst];
      e.valid  = mValid[inst];
      e.last   = (mValid[inst] != 0 && mHeld[inst] == mBL[inst]) ? 1 : 0;
      return e;
   endfunction

   // Drive one cycle of requests, queue the expected post-edge outputs,
   // and advance to the next falling edge.
   task automatic applyStimulus(input int rA, input int rB, input int rC);
      reqA = 4'(rA);
      reqB = 4'(rB);
      reqC = 5'(rC);
      expQ.push_back(modelStep(0, rA & 15));
      expQ.push_back(modelStep(1, rB & 15));
      expQ.push_back(modelStep(2, rC & 31));
      @(negedge clk);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " grantA"}, int'(grantA), 0);
      checkOutput({tag, " grantB"}, int'(grantB), 0);
      checkOutput({tag, " grantC"}, int'(grantC), 0);
      checkOutput({tag, " validA"}, int'(validA), 0);
      checkOutput({tag, " validB"}, int'(validB), 0);
      checkOutput({tag, " validC"}, int'(validC), 0);
      checkOutput({tag, " idB"}, int'(idB), 0);
      checkOutput({tag, " lastB"}, int'(lastB), 0);
   endtask

   // Monitor: shortly after each rising edge, compare every queued expectation.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         while (expQ.size() > 0) begin
            monE = expQ.pop_front();
            case (monE.inst)
               0: begin
                  checkOutput("grant inst0", int'(grantA), monE.grantV);
                  checkOutput("valid inst0", int'(validA), monE.valid);
                  checkOutput("grant_id inst0", int'(idA), monE.id);
                  checkOutput("burst_last inst0", int'(lastA), monE.last);
               end
               1: begin
                  checkOutput("grant inst1", int'(grantB), monE.grantV);
                  checkOutput("valid inst1", int'(validB), monE.valid);
                  checkOutput("grant_id inst1", int'(idB), monE.id);
                  checkOutput("burst_last inst1", int'(lastB), monE.last);
               end
               default: begin
                  checkOutput("grant inst2", int'(grantC), monE.grantV);
                  checkOutput("valid inst2", int'(validC), monE.valid);
                  checkOutput("grant_id inst2", int'(idC), monE.id);
                  checkOutput("burst_last inst2", int'(lastC), monE.last);
               end
            endcase
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      int pA, pB, pC;
      rst  = 1'b1;
      reqA = '0;
      reqB = '0;
      reqC = '0;
      resetModel();
      @(negedge clk);
      checkReset("reset");
      @(negedge clk);
      rst = 1'b0;

      // Everyone requesting: per-cycle rotation on A and C, bursts of 3 on B.
      repeat (8) applyStimulus(15, 15, 31);

      // Alternating pair, idle gap, then resume from the saved pointer.
      repeat (4) applyStimulus(5, $urandom_range(0, 15), $urandom_range(0, 31));
      repeat (3) applyStimulus(0, $urandom_range(0, 15), $urandom_range(0, 31));
      repeat (2) applyStimulus(5, $urandom_range(0, 15), $urandom_range(0, 31));

      // Two requesters sharing in bursts of three.
      repeat (9) applyStimulus($urandom_range(0, 15), 3, $urandom_range(0, 31));

      // Owner drops early, then a lone requester is re-granted without a gap.
      applyStimulus($urandom_range(0, 15), 6, $urandom_range(0, 31));
      repeat (6) applyStimulus($urandom_range(0, 15), 4, $urandom_range(0, 31));

      // Non-power-of-two wrap: pointer at 4, requesters 0 and 4 alternate.
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), 16);
      repeat (3) applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), 17);

      // Asynchronous reset in the middle of a burst held by requester 2.
      applyStimulus(0, 0, 0);
      repeat (2) applyStimulus(0, 4, 0);
      #2;
      rst  = 1'b1;
      reqA = '0;
      reqB = '0;
      reqC = '0;
      #1;
      checkReset("async reset");
      @(negedge clk);
      @(negedge clk);
      resetModel();
      rst = 1'b0;
      repeat (3) applyStimulus(15, 15, 31);

      // Random traffic, with requests tending to persist so bursts form.
      pA = 0;
      pB = 0;
      pC = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) pA = $urandom_range(0, 15);
         if ($urandom_range(0, 3) == 0) pB = $urandom_range(0, 15);
         if ($urandom_range(0, 3) == 0) pC = $urandom_range(0, 31);
         applyStimulus(pA, pB, pC);
      end

      applyStimulus(0, 0, 0);
      @(posedge clk);
      #2;
      checkOutput("scoreboard drained", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
